// File: rtl/fetch_pkg.sv
// Shared definitions for the prefetching fetch stage: entry layout and default
// reset PC.
package fetch_pkg;

  localparam int INSN_BYTES = 4;
  localparam int AWIDTH_DEFAULT = 32;
  localparam int DWIDTH_DEFAULT = 32;
  localparam logic [AWIDTH_DEFAULT-1:0] BASEADDR_DEFAULT = 32'h0100_0000;

  typedef struct packed {
    logic [AWIDTH_DEFAULT-1:0] pc;
    logic [DWIDTH_DEFAULT-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetched {pc, insn} pairs with flush.
// Head reads as zero while empty so downstream never sees stale data.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  entry_t                     push_data_i,
  input  logic                       pop_i,
  output entry_t                     head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            pop_ok;
  logic            push_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[tail_q] = push_data_i;
        tail_d        = tail_q + 1'b1;
      end
      if (pop_ok) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = (count_q != '0) ? mem_q[head_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch.sv
// Prefetching fetch stage: credit-limited sequential reads, in-order response
// capture into a queue, and redirect handling that retires in-flight reads as stale.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(BASEADDR_DEFAULT),
  parameter int                DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [AWIDTH-1:0] mem_addr_o,
  input  logic              mem_rsp_valid_i,
  input  logic [DWIDTH-1:0] mem_rsp_data_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 2;

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
  } entry_t;

  logic [AWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [AWIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     live_cnt_q, live_cnt_d;
  logic [CW-1:0]     stale_cnt_q, stale_cnt_d;
  logic [CW-1:0]     fifo_count;
  logic [SW-1:0]     budget_used;
  logic [AWIDTH-1:0] redirect_pc_aligned;
  logic              req_accept;
  logic              rsp_stale;
  logic              rsp_live;
  logic              fifo_push;
  entry_t            fifo_push_data;
  entry_t            fifo_head;
  logic              unused_pc_bits;

  assign unused_pc_bits      = ^redirect_pc_i[1:0];
  assign redirect_pc_aligned = {redirect_pc_i[AWIDTH-1:2], 2'b00};

  // Every read holds a queue slot until decode consumes it, so the queue cannot overflow.
  assign budget_used     = SW'(live_cnt_q) + SW'(stale_cnt_q) + SW'(fifo_count);
  assign mem_req_valid_o = !rst && (budget_used < SW'(DEPTH));
  assign mem_addr_o      = fetch_pc_q;
  assign req_accept      = mem_req_valid_o && mem_req_ready_i;

  assign rsp_stale = mem_rsp_valid_i && (stale_cnt_q != '0);
  assign rsp_live  = mem_rsp_valid_i && (stale_cnt_q == '0) && (live_cnt_q != '0);
  assign fifo_push = rsp_live && !redirect_i;
  assign fifo_push_data = '{pc: rsp_pc_q, insn: mem_rsp_data_i};

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    live_cnt_d  = live_cnt_q;
    stale_cnt_d = stale_cnt_q;
    if (redirect_i) begin
      fetch_pc_d  = redirect_pc_aligned;
      rsp_pc_d    = redirect_pc_aligned;
      live_cnt_d  = '0;
      stale_cnt_d = stale_cnt_q + live_cnt_q + CW'(req_accept) - CW'(rsp_stale || rsp_live);
    end else begin
      if (req_accept) begin
        fetch_pc_d = fetch_pc_q + AWIDTH'(INSN_BYTES);
      end
      if (rsp_live) begin
        rsp_pc_d = rsp_pc_q + AWIDTH'(INSN_BYTES);
      end
      live_cnt_d  = live_cnt_q + CW'(req_accept) - CW'(rsp_live);
      stale_cnt_d = stale_cnt_q - CW'(rsp_stale);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= BASEADDR;
      rsp_pc_q    <= BASEADDR;
      live_cnt_q  <= '0;
      stale_cnt_q <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      live_cnt_q  <= live_cnt_d;
      stale_cnt_q <= stale_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_i),
    .push_i      (fifo_push),
    .push_data_i (fifo_push_data),
    .pop_i       (insn_ready_i),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  assign insn_valid_o = (fifo_count != '0);
  assign pc_o         = fifo_head.pc;
  assign insn_o       = fifo_head.insn;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: in-order memory model with per-request epochs and a
// stream scoreboard for delivered PCs, plus directed reset/fill/redirect scenarios.
module tb_fetch_prefetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        insn_valid_o;
  logic        insn_ready_i;
  logic [31:0] pc_o;
  logic [31:0] insn_o;

  always #5 clk = ~clk;

  fetch_prefetch #(
    .DWIDTH   (32),
    .AWIDTH   (32),
    .BASEADDR (BASE),
    .DEPTH    (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_addr_o      (mem_addr_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .insn_valid_o    (insn_valid_o),
    .insn_ready_i    (insn_ready_i),
    .pc_o            (pc_o),
    .insn_o          (insn_o)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;

  req_t        pend[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          occ = 0;
  int          epoch = 0;
  int          acc_cnt = 0;
  logic [31:0] exp_pc = BASE;
  logic [31:0] exp_req = BASE;

  int          ready_pct = 100;
  int          irdy_pct = 100;
  int          lat = 1;
  int          redir_permille = 0;
  logic        rst_drv = 1'b1;
  logic        redir_now = 1'b0;
  logic        redir_if_busy = 1'b0;
  logic [31:0] redir_pc = '0;

  logic        s_reqv, s_acc, s_pop, s_ivalid, s_redir;
  logic [31:0] s_addr, s_pc, s_insn;
  logic        pop_seen = 1'b0;
  logic [31:0] first_pop_pc = '0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, update models, wait for posedge.
  task automatic step();
    logic rsp_live;
    int   due;
    req_t r;
    @(negedge clk);
    rst             = rst_drv;
    mem_req_ready_i = ($urandom_range(99) < ready_pct);
    insn_ready_i    = ($urandom_range(99) < irdy_pct);
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = $urandom();
    rsp_live        = 1'b0;
    if (!rst_drv && pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = data_of(pend[0].addr);
      rsp_live        = (pend[0].epoch == epoch);
    end
    redirect_pc_i = redir_now ? redir_pc : $urandom();
    redirect_i    = redir_now || (!rst_drv && ($urandom_range(999) < redir_permille));
    if (redir_if_busy && !rst_drv && mem_req_valid_o && mem_req_ready_i && mem_rsp_valid_i) begin
      redirect_i    = 1'b1;
      redirect_pc_i = redir_pc;
    end
    s_redir = redirect_i;
    #1;
    s_reqv   = mem_req_valid_o;
    s_addr   = mem_addr_o;
    s_ivalid = insn_valid_o;
    s_pc     = pc_o;
    s_insn   = insn_o;
    s_acc    = s_reqv && mem_req_ready_i;
    s_pop    = s_ivalid && insn_ready_i;
    if (rst_drv) begin
      check("req_valid_in_reset", 64'(s_reqv), 64'(1'b0));
      pend.delete();
      occ     = 0;
      exp_pc  = BASE;
      exp_req = BASE;
      epoch++;
    end else begin
      check("req_valid", 64'(s_reqv), 64'(pend.size() + occ < DEPTH));
      if (s_reqv) check("req_addr", 64'(s_addr), 64'(exp_req));
      check("insn_valid", 64'(s_ivalid), 64'(occ != 0));
      if (s_pop) begin
        check("pop_pc", 64'(s_pc), 64'(exp_pc));
        check("pop_insn", 64'(s_insn), 64'(data_of(exp_pc)));
        if (!pop_seen) begin
          pop_seen     = 1'b1;
          first_pop_pc = s_pc;
        end
        exp_pc = exp_pc + 32'd4;
      end else if (!s_ivalid) begin
        check("empty_head", {s_pc, s_insn}, 64'd0);
      end
      if (mem_rsp_valid_i) void'(pend.pop_front());
      if (s_acc) begin
        due = cyc + lat;
        if (pend.size() > 0 && pend[$].due > due) due = pend[$].due;
        r.addr  = s_addr;
        r.due   = due;
        r.epoch = epoch;
        pend.push_back(r);
        exp_req = exp_req + 32'd4;
        acc_cnt++;
      end
      if (s_redir) begin
        occ     = 0;
        exp_pc  = redirect_pc_i & ~32'd3;
        exp_req = redirect_pc_i & ~32'd3;
        epoch++;
      end else begin
        occ = occ + int'(rsp_live) - int'(s_pop);
      end
      check("budget", 64'(pend.size() + occ <= DEPTH), 64'(1'b1));
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    rst             = 1'b1;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    redirect_i      = 1'b0;
    redirect_pc_i   = '0;
    insn_ready_i    = 1'b0;

    // Reset and first fetches with 1-cycle memory
    rst_drv = 1'b1;
    step();
    step();
    rst_drv = 1'b0;
    step();
    check("rel_ivalid", 64'(s_ivalid), 64'(1'b0));
    check("rel_head", {s_pc, s_insn}, 64'd0);
    check("rel_reqv", 64'(s_reqv), 64'(1'b1));
    check("rel_addr", 64'(s_addr), 64'(BASE));
    step();
    check("ivalid_c1", 64'(s_ivalid), 64'(1'b0));
    step();
    check("first_out", {31'd0, s_ivalid, s_pc}, {31'd0, 1'b1, BASE});
    step();
    check("second_out", {31'd0, s_ivalid, s_pc}, {31'd0, 1'b1, BASE + 32'd4});
    step();
    check("third_out", {31'd0, s_ivalid, s_pc}, {31'd0, 1'b1, BASE + 32'd8});
    repeat (8) step();

    // Decode stalled: credit budget caps accepted requests
    rst_drv = 1'b1;
    step();
    rst_drv  = 1'b0;
    irdy_pct = 0;
    acc_cnt  = 0;
    repeat (12) step();
    check("fill_accepts", 64'(acc_cnt), 64'd4);
    check("fill_reqv", 64'(s_reqv), 64'(1'b0));
    check("fill_ivalid", 64'(s_ivalid), 64'(1'b1));
    irdy_pct = 100;
    acc_cnt  = 0;
    step();
    irdy_pct = 0;
    repeat (10) step();
    check("refill_accepts", 64'(acc_cnt), 64'd1);

    // One-cycle reset with a full queue
    rst_drv = 1'b1;
    step();
    rst_drv = 1'b0;
    step();
    check("rst_ivalid", 64'(s_ivalid), 64'(1'b0));
    check("rst_reqv", 64'(s_reqv), 64'(1'b1));
    check("rst_addr", 64'(s_addr), 64'(BASE));

    // Random ready, 5-cycle latency
    lat       = 5;
    ready_pct = 60;
    irdy_pct  = 70;
    repeat (300) step();

    // Redirect with three reads in flight
    ready_pct = 0;
    irdy_pct  = 100;
    repeat (15) step();
    acc_cnt   = 0;
    ready_pct = 100;
    repeat (3) step();
    ready_pct = 0;
    check("d_inflight", 64'(acc_cnt), 64'd3);
    redir_now = 1'b1;
    redir_pc  = 32'h0100_0103;
    step();
    redir_now = 1'b0;
    pop_seen  = 1'b0;
    step();
    check("d_empty_after", 64'(s_ivalid), 64'(1'b0));
    ready_pct = 100;
    for (int i = 0; i < 40 && !pop_seen; i++) step();
    check("d_pop_seen", 64'(pop_seen), 64'(1'b1));
    check("d_first_pc", 64'(first_pop_pc), 64'h0100_0100);

    // Redirect coinciding with an accept and a response
    lat       = 1;
    ready_pct = 100;
    irdy_pct  = 100;
    repeat (6) step();
    redir_pc      = 32'h0200_0010;
    redir_if_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_redir) break;
    end
    redir_if_busy = 1'b0;
    check("e_fired", 64'(s_redir), 64'(1'b1));
    pop_seen = 1'b0;
    for (int i = 0; i < 20 && !pop_seen; i++) step();
    check("e_pop_seen", 64'(pop_seen), 64'(1'b1));
    check("e_first_pc", 64'(first_pop_pc), 64'h0200_0010);

    // Address wrap at the top of the space
    lat       = 2;
    redir_now = 1'b1;
    redir_pc  = 32'hFFFF_FFF6;
    step();
    redir_now = 1'b0;
    repeat (14) step();

    // Random traffic with random redirects
    lat            = 3;
    ready_pct      = 75;
    irdy_pct       = 60;
    redir_permille = 30;
    repeat (400) step();
    redir_permille = 0;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
